// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: programmable interval timer with an internal clock-enable
// prescaler. It counts a loaded number of base ticks and pulses expire at
// terminal count, then either stops (one-shot) or reloads (periodic).
//
// Control handshake: start, stop and load are level inputs sampled on every
// rising clkin edge. In RUN the priority is rst > stop > start > tick. A start
// is accepted in IDLE only when stop is low and period_reg is nonzero. A start
// in RUN restarts the period. load is honoured only in IDLE. tick is a
// combinational clock enable. busy, expire and remaining are registered.
module tick_timer_ctrl #(
  parameter int PRESCALE = 5000,
  parameter int CNT_W    = 16,
  parameter int PS_W     = 13
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  output logic             busy,
  output logic             tick,
  output logic             expire,
  output logic [CNT_W-1:0] remaining,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] period_reg;
  logic             mode_reg;
  logic [PS_W-1:0]  pcount;

  // Base tick: one clkin cycle out of every PRESCALE while running.
  assign tick      = (state == RUN) && (pcount == PS_LAST);
  assign state_dbg = (state == RUN);

  // Timer FSM: period load, start/stop/restart, prescaler and tick countdown.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      expire     <= 1'b0;
      remaining  <= '0;
      period_reg <= '0;
      pcount     <= '0;
      mode_reg   <= 1'b0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            period_reg <= period_in;
          end
          // A coincident load has not landed yet, so the old period is used.
          if (start && !stop && (period_reg != '0)) begin
            state     <= RUN;
            busy      <= 1'b1;
            remaining <= period_reg;
            pcount    <= '0;
            mode_reg  <= mode;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort wins over a coincident tick: no expire.
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
            pcount    <= '0;
          end else if (start) begin
            // Restart discards any coincident tick.
            remaining <= period_reg;
            pcount    <= '0;
            mode_reg  <= mode;
          end else if (tick) begin
            pcount <= '0;
            if (remaining > ONE) begin
              remaining <= remaining - ONE;
            end else if (remaining == ONE) begin
              expire <= 1'b1;
              if (mode_reg) begin
                remaining <= period_reg;
              end else begin
                remaining <= '0;
                state     <= IDLE;
                busy      <= 1'b0;
              end
            end else begin
              // Unreachable in RUN; park safely rather than underflow.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pcount <= pcount + PS_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl with PRESCALE=4.
module tb_tick_timer_ctrl;

  localparam int PRESCALE = 4;
  localparam int CNT_W    = 16;
  localparam int PS_W     = 4;

  logic             clkin = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] period_in = '0;
  logic             busy;
  logic             tick;
  logic             expire;
  logic [CNT_W-1:0] remaining;
  logic             state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  tick_timer_ctrl #(
    .PRESCALE(PRESCALE),
    .CNT_W   (CNT_W),
    .PS_W    (PS_W)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .load     (load),
    .period_in(period_in),
    .busy     (busy),
    .tick     (tick),
    .expire   (expire),
    .remaining(remaining),
    .state_dbg(state_dbg)
  );

  // Clock and sampling point (#1 after each rising edge).
  always #5 clkin = ~clkin;

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_load(input int p);
    load = 1'b1;
    period_in = CNT_W'(p);
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1;
    mode = m;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if ({busy, tick, expire, state_dbg} !== 4'b0000 || remaining !== '0) begin
      n_bad++;
      $display("FAIL reset: busy=%b tick=%b expire=%b state=%b remaining=%0d, want all 0",
               busy, tick, expire, state_dbg, remaining);
    end
  endtask

  // One-shot, period 3: ticks when j%4==3, expire and busy drop at j=12.
  task automatic test_oneshot(input string tag);
    int ticks;
    int exp_rem;
    ticks = 0;
    do_load(3);
    do_start(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 16'd3 || expire !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_start: busy=%b rem=%0d expire=%b, want 1/3/0", tag, busy, remaining, expire);
    end
    for (int j = 1; j <= 13; j++) begin
      cyc();
      if (tick === 1'b1) ticks++;
      if (j < 12) begin
        exp_rem = 3 - j / 4;
        n_cmp++;
        if (tick !== ((j % 4) == 3) || expire !== 1'b0 || busy !== 1'b1 ||
            remaining !== CNT_W'(exp_rem)) begin
          n_bad++;
          $display("FAIL %s_run j=%0d: tick=%b expire=%b busy=%b rem=%0d, want %b/0/1/%0d",
                   tag, j, tick, expire, busy, remaining, ((j % 4) == 3), exp_rem);
        end
      end else begin
        n_cmp++;
        if (expire !== (j == 12) || busy !== 1'b0 || remaining !== '0 || tick !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_end j=%0d: expire=%b busy=%b rem=%0d tick=%b, want %b/0/0/0",
                   tag, j, expire, busy, remaining, tick, (j == 12));
        end
      end
    end
    n_cmp++;
    if (ticks != 3) begin
      n_bad++;
      $display("FAIL %s_ticks: got %0d ticks, want 3", tag, ticks);
    end
  endtask

  // Periodic, period 2: expire every 8 cycles, remaining reloads to 2.
  task automatic test_periodic();
    int n_exp;
    int exp_rem;
    n_exp = 0;
    do_load(2);
    do_start(1'b1);
    for (int j = 1; j <= 34; j++) begin
      cyc();
      if (expire === 1'b1) n_exp++;
      exp_rem = 2 - (j % 8) / 4;
      n_cmp++;
      if (expire !== ((j % 8) == 0) || busy !== 1'b1 || remaining !== CNT_W'(exp_rem)) begin
        n_bad++;
        $display("FAIL periodic j=%0d: expire=%b busy=%b rem=%0d, want %b/1/%0d",
                 j, expire, busy, remaining, ((j % 8) == 0), exp_rem);
      end
    end
    n_cmp++;
    if (n_exp != 4) begin
      n_bad++;
      $display("FAIL periodic_count: got %0d expires, want 4", n_exp);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL periodic_stop: busy=%b rem=%0d, want 0/0", busy, remaining);
    end
  endtask

  // Stop on the cycle of the final tick: no expire.
  task automatic test_stop_final_tick();
    do_load(2);
    do_start(1'b0);
    for (int j = 1; j <= 7; j++) cyc();
    n_cmp++;
    if (tick !== 1'b1 || remaining !== 16'd1) begin
      n_bad++;
      $display("FAIL stop_pre: tick=%b rem=%0d, want 1/1", tick, remaining);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_cmp++;
    if (expire !== 1'b0 || busy !== 1'b0 || remaining !== '0) begin
      n_bad++;
      $display("FAIL stop_final: expire=%b busy=%b rem=%0d, want 0/0/0", expire, busy, remaining);
    end
    cyc();
    n_cmp++;
    if (expire !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_after: expire=%b tick=%b, want 0/0", expire, tick);
    end
  endtask

  // Restart while remaining=1 and the final tick coincides.
  task automatic test_restart();
    do_load(2);
    do_start(1'b0);
    for (int j = 1; j <= 7; j++) cyc();
    do_start(1'b0);
    n_cmp++;
    if (expire !== 1'b0 || remaining !== 16'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: expire=%b rem=%0d busy=%b, want 0/2/1", expire, remaining, busy);
    end
    for (int j = 1; j <= 8; j++) begin
      cyc();
      n_cmp++;
      if (expire !== (j == 8) || tick !== ((j % 4) == 3)) begin
        n_bad++;
        $display("FAIL restart_run j=%0d: expire=%b tick=%b, want %b/%b",
                 j, expire, tick, (j == 8), ((j % 4) == 3));
      end
    end
  endtask

  // Zero period ignored; load+start uses old period; load in RUN ignored.
  task automatic test_zero_and_load();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      n_cmp++;
      if (busy !== 1'b0 || tick !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_period j=%0d: busy=%b tick=%b, want 0/0", j, busy, tick);
      end
    end
    load = 1'b1;
    period_in = 16'd3;
    cyc();
    load = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL load_start_same: busy=%b, want 0", busy);
    end
    do_start(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 16'd3) begin
      n_bad++;
      $display("FAIL start_after_load: busy=%b rem=%0d, want 1/3", busy, remaining);
    end
    do_load(5);
    for (int j = 2; j <= 12; j++) begin
      cyc();
      n_cmp++;
      if (expire !== (j == 12)) begin
        n_bad++;
        $display("FAIL load_in_run j=%0d: expire=%b, want %b", j, expire, (j == 12));
      end
    end
    do_start(1'b0);
    n_cmp++;
    if (remaining !== 16'd3) begin
      n_bad++;
      $display("FAIL period_kept: rem=%0d, want 3", remaining);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // Reset mid-run clears everything; a fresh one-shot run then behaves normally.
  task automatic test_reset_mid_run();
    do_load(3);
    do_start(1'b1);
    for (int j = 0; j < 5; j++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if ({busy, tick, expire, state_dbg} !== 4'b0000 || remaining !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b tick=%b expire=%b state=%b rem=%0d, want all 0",
               busy, tick, expire, state_dbg, remaining);
    end
    do_start(1'b0);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_clears_period: busy=%b, want 0", busy);
    end
    test_oneshot("after_reset");
  endtask

  initial begin
    test_reset();
    test_oneshot("oneshot");
    test_periodic();
    test_stop_final_tick();
    test_restart();
    test_zero_and_load();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
